// File: rtl/morse_round_ctrl_if.sv
// Pulse/word inputs and round status outputs of morse_round_ctrl.
// master drives the pulses; slave is the controller.
interface morse_round_ctrl_if #(
  parameter int SYM_W  = 10,
  parameter int ADDR_W = 4
);
  logic              tick;
  logic              next_pulse;
  logic              done_pulse;
  logic [SYM_W-1:0]  sym_in;
  logic [1:0]        state;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [1:0]        correct;
  logic [ADDR_W:0]   match_cnt;
  logic              full;
  logic              win;

  modport master (
    output tick, next_pulse, done_pulse, sym_in,
    input  state, wr_ptr, rd_ptr, correct,
    input  match_cnt, full, win
  );

  modport slave (
    input  tick, next_pulse, done_pulse, sym_in,
    output state, wr_ptr, rd_ptr, correct,
    output match_cnt, full, win
  );
endinterface

// File: rtl/morse_round_ctrl.sv
// Two-player Morse round: P1 stores words, P2 guesses them back.
// Define MORSE_TIMEOUT_EN to give each guess a tick-based time limit.
module morse_round_ctrl #(
  parameter int SYM_W         = 10,
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int TIMEOUT_TICKS = 20
) (
  input  logic               clock,
  input  logic               reset,
  morse_round_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    P1_ENTRY = 2'b01,
    P2_GUESS = 2'b10,
    RESULT   = 2'b11
  } st_e;

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  st_e              st_q, st_d;
  logic [ADDR_W:0]  wr_q, rd_q, mc_q;
  logic [1:0]       cor_q;
  logic [SYM_W-1:0] mem [DEPTH];

  logic             full_w, wr_fire, guess;
  logic             hit, expire, adv, clr;
  logic [ADDR_W:0]  wr_nx, rd_nx;

  assign full_w  = (wr_q == DEPTH_V);
  assign wr_fire = (st_q == P1_ENTRY) &&
                   bus.next_pulse && !full_w;
  assign wr_nx   = wr_fire ? wr_q + ONE : wr_q;
  assign guess   = (st_q == P2_GUESS) && bus.next_pulse;
  assign hit     = (mem[rd_q[ADDR_W-1:0]] == bus.sym_in);
  assign adv     = guess || expire;
  assign rd_nx   = adv ? rd_q + ONE : rd_q;
  assign clr     = (st_q == RESULT) && bus.done_pulse;

`ifdef MORSE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT_TICKS - 1);

  logic [CNT_W-1:0] cnt_q;

  // A guess on the expiry cycle wins over the timeout.
  assign expire = (st_q == P2_GUESS) && bus.tick &&
                  !bus.next_pulse && (cnt_q == LAST);

  always_ff @(posedge clock) begin
    if (reset)
      cnt_q <= '0;
    else if (st_q != P2_GUESS || bus.next_pulse || expire)
      cnt_q <= '0;
    else if (bus.tick)
      cnt_q <= cnt_q + 1'b1;
  end
`else
  logic unused_tick;
  assign unused_tick = bus.tick;
  assign expire      = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset)
      st_q <= IDLE;
    else
      st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:
        if (bus.done_pulse) st_d = P1_ENTRY;
      P1_ENTRY:
        if (bus.done_pulse && wr_nx != '0)
          st_d = P2_GUESS;
      P2_GUESS:
        if ((adv && rd_nx == wr_q) || bus.done_pulse)
          st_d = RESULT;
      RESULT:
        if (bus.done_pulse) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mc_q  <= '0;
      cor_q <= 2'b00;
    end else begin
      if (wr_fire) wr_q <= wr_nx;
      if (adv) begin
        rd_q  <= rd_nx;
        cor_q <= (guess && hit) ? 2'b01 : 2'b10;
        if (guess && hit) mc_q <= mc_q + ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wr_fire)
      mem[wr_q[ADDR_W-1:0]] <= bus.sym_in;
  end

  always_comb begin
    bus.state     = st_q;
    bus.wr_ptr    = wr_q;
    bus.rd_ptr    = rd_q;
    bus.correct   = cor_q;
    bus.match_cnt = mc_q;
    bus.full      = full_w;
    bus.win       = (st_q == RESULT) && (mc_q == wr_q);
  end
endmodule

// File: tb/tb_morse_round_ctrl.sv
// Directed bench for morse_round_ctrl with an expected-status queue.
// Timeout scenario runs when MORSE_TIMEOUT_EN is defined.
module tb_morse_round_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total  = 0;
  int   passed = 0;

  always #5 clock = ~clock;

  morse_round_ctrl_if #(.SYM_W(10), .ADDR_W(4)) bus ();

  morse_round_ctrl #(
    .SYM_W(10), .DEPTH(16), .ADDR_W(4), .TIMEOUT_TICKS(20)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0] st;
    logic [4:0] wr;
    logic [4:0] rd;
    logic [1:0] cor;
    logic [4:0] mc;
    logic       full;
    logic       win;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic push(input logic [1:0] st,
                      input logic [4:0] wr,
                      input logic [4:0] rd,
                      input logic [1:0] cor,
                      input logic [4:0] mc,
                      input logic full,
                      input logic win);
    exp_t e;
    e.st = st; e.wr = wr; e.rd = rd; e.cor = cor;
    e.mc = mc; e.full = full; e.win = win;
    sb.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    total++;
    assert (sb.size() != 0) passed++;
    else $error("FAIL %s: got empty queue expected entry",
                tag);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".state"}, 32'(bus.state), 32'(e.st));
      chk({tag, ".wr_ptr"}, 32'(bus.wr_ptr), 32'(e.wr));
      chk({tag, ".rd_ptr"}, 32'(bus.rd_ptr), 32'(e.rd));
      chk({tag, ".correct"}, 32'(bus.correct), 32'(e.cor));
      chk({tag, ".match_cnt"}, 32'(bus.match_cnt), 32'(e.mc));
      chk({tag, ".full"}, 32'(bus.full), 32'(e.full));
      chk({tag, ".win"}, 32'(bus.win), 32'(e.win));
    end
  endtask

  // One clock with the given pulses; outputs sampled 1ns after the edge.
  task automatic cyc(input logic n, input logic d,
                     input logic t, input logic [9:0] s);
    @(negedge clock);
    bus.next_pulse = n;
    bus.done_pulse = d;
    bus.tick       = t;
    bus.sym_in     = s;
    @(posedge clock);
    #1;
    bus.next_pulse = 1'b0;
    bus.done_pulse = 1'b0;
    bus.tick       = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.tick = 1'b0; bus.next_pulse = 1'b0;
    bus.done_pulse = 1'b0; bus.sym_in = '0;

    // reset
    reset = 1'b1;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    reset = 1'b0;
    push(0, 0, 0, 0, 0, 0, 0); compare("reset");

    // round 1: all guesses right
    cyc(0, 1, 0, 0); push(1, 0, 0, 0, 0, 0, 0); compare("r1.done");
    cyc(1, 0, 0, 10'h0A5); push(1, 1, 0, 0, 0, 0, 0); compare("r1.w0");
    cyc(1, 0, 0, 10'h3FF); push(1, 2, 0, 0, 0, 0, 0); compare("r1.w1");
    cyc(1, 0, 0, 10'h001); push(1, 3, 0, 0, 0, 0, 0); compare("r1.w2");
    cyc(0, 1, 0, 0); push(2, 3, 0, 0, 0, 0, 0); compare("r1.to_p2");
    cyc(1, 0, 0, 10'h0A5); push(2, 3, 1, 1, 1, 0, 0); compare("r1.g0");
    cyc(1, 0, 0, 10'h3FF); push(2, 3, 2, 1, 2, 0, 0); compare("r1.g1");
    cyc(1, 0, 0, 10'h001); push(3, 3, 3, 1, 3, 0, 1); compare("r1.g2");
    cyc(0, 1, 0, 0); push(0, 0, 0, 0, 0, 0, 0); compare("r1.idle");

    // round 2: middle guess wrong
    cyc(0, 1, 0, 0); push(1, 0, 0, 0, 0, 0, 0); compare("r2.done");
    cyc(1, 0, 0, 10'h0A5); cyc(1, 0, 0, 10'h3FF);
    cyc(1, 0, 0, 10'h001); push(1, 3, 0, 0, 0, 0, 0); compare("r2.entry");
    cyc(0, 1, 0, 0); push(2, 3, 0, 0, 0, 0, 0); compare("r2.to_p2");
    cyc(1, 0, 0, 10'h0A5); push(2, 3, 1, 1, 1, 0, 0); compare("r2.g0");
    cyc(0, 0, 0, 10'h3FF); push(2, 3, 1, 1, 1, 0, 0); compare("r2.hold");
    cyc(1, 0, 0, 10'h000); push(2, 3, 2, 2, 1, 0, 0); compare("r2.g1");
    cyc(1, 0, 0, 10'h001); push(3, 3, 3, 1, 2, 0, 0); compare("r2.g2");
    cyc(0, 1, 0, 0); push(0, 0, 0, 0, 0, 0, 0); compare("r2.idle");

    // empty done ignored, then next+done together
    cyc(0, 1, 0, 0); push(1, 0, 0, 0, 0, 0, 0); compare("r3.done");
    cyc(0, 1, 0, 0); push(1, 0, 0, 0, 0, 0, 0); compare("r3.empty_done");
    cyc(1, 1, 0, 10'h123); push(2, 1, 0, 0, 0, 0, 0); compare("r3.both");
    cyc(1, 0, 0, 10'h123); push(3, 1, 1, 1, 1, 0, 1); compare("r3.g0");
    cyc(0, 1, 0, 0); push(0, 0, 0, 0, 0, 0, 0); compare("r3.idle");

    // fill to DEPTH, 17th word ignored
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 10'(10'h100 + i));
    push(1, 16, 0, 0, 0, 1, 0); compare("r4.full");
    cyc(1, 0, 0, 10'h3AA); push(1, 16, 0, 0, 0, 1, 0); compare("r4.over");
    cyc(0, 1, 0, 0); push(2, 16, 0, 0, 0, 1, 0); compare("r4.to_p2");
    cyc(1, 0, 0, 10'h100); push(2, 16, 1, 1, 1, 1, 0); compare("r4.buf0");
    cyc(1, 0, 0, 10'h101); push(2, 16, 2, 1, 2, 1, 0); compare("r4.buf1");

    // reset mid-round with rd_ptr=2
    reset = 1'b1;
    cyc(1, 1, 1, 10'h102);
    reset = 1'b0;
    push(0, 0, 0, 0, 0, 0, 0); compare("r5.reset");
    cyc(1, 0, 0, 10'h055); push(0, 0, 0, 0, 0, 0, 0); compare("r5.idle_next");
    cyc(0, 1, 0, 0); push(1, 0, 0, 0, 0, 0, 0); compare("r5.done");

    // one word, then ticks without a guess
    cyc(1, 0, 0, 10'h055); cyc(0, 1, 0, 0);
    push(2, 1, 0, 0, 0, 0, 0); compare("r6.to_p2");
    for (int i = 0; i < 19; i++) cyc(0, 0, 1, 0);
    push(2, 1, 0, 0, 0, 0, 0); compare("r6.t19");
`ifdef MORSE_TIMEOUT_EN
    cyc(0, 0, 1, 0); push(3, 1, 1, 2, 0, 0, 0); compare("r6.timeout");
`else
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
    push(2, 1, 0, 0, 0, 0, 0); compare("r6.no_timeout");
    cyc(0, 1, 0, 0); push(3, 1, 0, 0, 0, 0, 0); compare("r6.early");
`endif
    cyc(0, 1, 0, 0); push(0, 0, 0, 0, 0, 0, 0); compare("r6.idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/morse_round_ctrl.md
MORSE_ROUND_CTRL -- requirements
Module: morse_round_ctrl

Interface
REQ-001 The block SHALL have parameter SYM_W, default 10, giving the bit width of one code word.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the maximum number of stored code words; it is a power of two and at least 2.
REQ-003 The block SHALL have parameter ADDR_W, default 4, giving the pointer width, where DEPTH = 2**ADDR_W.
REQ-004 The block SHALL have parameter TIMEOUT_TICKS, default 20, giving the number of tick pulses allowed per guess.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous active-high reset.
- tick  in  1  one-cycle timing enable (rate-divided pulse).
- next_pulse  in  1  one-cycle pulse: commit a word or a guess.
- done_pulse  in  1  one-cycle pulse: advance the phase.
- sym_in  in  SYM_W  word presented by the active player.
- state  out  2  00 IDLE, 01 P1_ENTRY, 10 P2_GUESS, 11 RESULT.
- wr_ptr  out  ADDR_W+1  number of stored words.
- rd_ptr  out  ADDR_W+1  number of guessed words.
- correct  out  2  01 last guess matched, 10 mismatched or timed out, 00 none.
- match_cnt  out  ADDR_W+1  count of correct guesses.
- full  out  1  wr_ptr == DEPTH.
- win  out  1  asserted in RESULT when match_cnt == wr_ptr.

Function
REQ-006 Storage SHALL be a DEPTH x SYM_W register array, written only in P1_ENTRY and read only in P2_GUESS.
REQ-007 IDLE SHALL move to P1_ENTRY on done_pulse; it SHALL ignore next_pulse.
REQ-008 In P1_ENTRY, next_pulse with full=0 SHALL write sym_in to buf[wr_ptr] and increment wr_ptr on the same edge.
REQ-009 In P1_ENTRY, next_pulse with full=1 SHALL be ignored, with no write and no pointer change.
REQ-010 In P1_ENTRY, done_pulse SHALL move to P2_GUESS only if wr_ptr is nonzero after any same-cycle write.
- With wr_ptr==0 and no same-cycle write, done_pulse SHALL be ignored.
REQ-011 In P2_GUESS, next_pulse SHALL compare sym_in with buf[rd_ptr[ADDR_W-1:0]] across all SYM_W bits, then:
- set correct to 01 on match or 10 on mismatch;
- increment match_cnt on match;
- increment rd_ptr.
All results SHALL be visible one cycle after the pulse.
REQ-012 When rd_ptr reaches wr_ptr, the state SHALL become RESULT on the same edge that rd_ptr is incremented.
REQ-013 In P2_GUESS, done_pulse SHALL move to RESULT early; a same-cycle next_pulse SHALL still be evaluated first.
REQ-014 In RESULT, win SHALL equal (match_cnt == wr_ptr); in all other states win SHALL be 0.
REQ-015 In RESULT, done_pulse SHALL return to IDLE and clear wr_ptr, rd_ptr, match_cnt and correct; buffer contents need not be cleared.
REQ-016 In P1_ENTRY, a same-cycle next_pulse and done_pulse SHALL write the word first, then apply REQ-010.
REQ-017 Pointers SHALL never wrap: wr_ptr saturates at DEPTH, and rd_ptr never exceeds wr_ptr.
REQ-018 correct SHALL hold its value until the next guess, timeout or return to IDLE.

Reset
REQ-019 reset SHALL take priority over all inputs and force:
- state=IDLE;
- wr_ptr=0, rd_ptr=0, match_cnt=0;
- correct=00, win=0, full=0;
- timeout counter=0.
REQ-020 Reset asserted mid-round SHALL abandon the round; the first pulse after release SHALL be treated as in IDLE.

Configuration
REQ-021 Macro MORSE_TIMEOUT_EN SHALL select the per-guess timeout feature.
REQ-022 With MORSE_TIMEOUT_EN defined:
- A tick counter SHALL clear on entry to P2_GUESS and on each next_pulse.
- The counter SHALL count tick pulses while in P2_GUESS.
- When the counter reaches TIMEOUT_TICKS, the block SHALL act as a mismatched guess (correct=10, rd_ptr+1, no match_cnt change), clear the counter, and apply REQ-012.
- If next_pulse arrives on the expiry cycle, next_pulse SHALL win and no timeout SHALL occur.
REQ-023 Without MORSE_TIMEOUT_EN, the block SHALL have no counter logic, SHALL ignore tick, and SHALL wait in P2_GUESS indefinitely.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- reset; done; next x3 with sym_in 0x0A5, 0x3FF, 0x001; done; guess 0x0A5, 0x3FF, 0x001 -> correct=01 after each, match_cnt=3, state=11, win=1.
- Same entry; guesses 0x0A5, 0x000, 0x001 -> correct 01,10,01; match_cnt=2; win=0.
- 17 next_pulses in P1_ENTRY -> wr_ptr=16, full=1, 17th ignored; buf[0] unchanged.
- done in P1_ENTRY with wr_ptr=0 -> state stays 01; simultaneous next+done -> wr_ptr=1, state=10.
- MORSE_TIMEOUT_EN, TIMEOUT_TICKS=20, one stored word, 20 ticks without next -> correct=10, rd_ptr=1, state=11, win=0.
- reset pulsed in P2_GUESS with rd_ptr=2 -> all outputs at reset values next cycle; done -> state=01.
